// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and types for the UART receive FIFO block.
//   - rx_state_e       : receiver FSM state encoding
//   - BAUD_DIV_DEFAULT : 434 cycles/bit (40 MHz at ~92 kbaud)
//   - ptr_width()      : FIFO pointer width, clog2 of the depth
package uart_rx_pkg;

  localparam int unsigned BAUD_DIV_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: firmware-side register interface of the UART receiver.
//   rd_en_i / clr_err_i       : pop strobe and sticky-error clear (firmware -> block)
//   rd_data_o / rx_valid_o    : FWFT head byte and not-empty flag
//   irq_o                     : level interrupt, mirrors rx_valid_o
//   frame_err_o / overrun_o   : sticky error flags
//   parity_err_o              : sticky parity error, only with UART_RX_PARITY_EN
interface uart_rx_fifo_if;
  logic       rd_en_i;
  logic       clr_err_i;
  logic [7:0] rd_data_o;
  logic       rx_valid_o;
  logic       irq_o;
  logic       frame_err_o;
  logic       overrun_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  // Firmware / register-slave side
  modport master (
    output rd_en_i, clr_err_i,
    input  rd_data_o, rx_valid_o, irq_o, frame_err_o, overrun_o
`ifdef UART_RX_PARITY_EN
    , input parity_err_o
`endif
  );

  // Receiver block side
  modport slave (
    input  rd_en_i, clr_err_i,
    output rd_data_o, rx_valid_o, irq_o, frame_err_o, overrun_o
`ifdef UART_RX_PARITY_EN
    , output parity_err_o
`endif
  );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, power-of-two depth.
//   clk_i, rst_i   : clock, synchronous active-high reset (flushes, zeroes storage)
//   push_i/data_i  : write strobe and data; accepted when not full or when popping
//   pop_i          : retire head; ignored when empty
//   head_o         : current head entry
//   full_o/empty_o : occupancy flags
module sync_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer/occupancy next state; pointers wrap naturally at a power-of-two depth
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a FWFT byte FIFO.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   rx_i               : asynchronous serial input, idle high
//   bus (slave)        : pop/clear strobes, head byte, valid/irq, sticky error flags
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit (11-bit frame)
// and the parity_err_o flag.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           rx_i,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] START  = ST_START;
  localparam logic [2:0] DATA   = ST_DATA;
  localparam logic [2:0] STOP   = ST_STOP;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = ST_PARITY;
`endif

  logic             sync1_q, sync2_q, rx_prev_q;
  logic             rx_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             tick_c;
  logic             push_c, frame_evt_c, overrun_evt_c;
  logic [7:0]       fifo_head;
  logic             fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
  logic             par_evt_c;
`endif

  assign rx_s   = sync2_q;
  assign tick_c = (cnt_q == CNT_ONE);

  // Receiver FSM: next state, bit timing and per-frame events
  always_comb begin
    state_d     = state_q;
    cnt_d       = tick_c ? FULL_LOAD : cnt_q - CNT_ONE;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_c      = 1'b0;
    frame_evt_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_evt_c   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        // Edge, not level: a held-low break after a bad stop cannot restart
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (tick_c) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_c) begin
          state_d = STOP;
          if (rx_s != ^shift_q) begin
            par_bad_d = 1'b1;
            par_evt_c = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick_c) begin
          state_d = IDLE;
          if (!rx_s) frame_evt_c = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (!par_bad_q) push_c = 1'b1;
`else
          else push_c = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO only drops the byte if no pop frees a slot this cycle
  assign overrun_evt_c = push_c && fifo_full && !bus.rd_en_i;

  // Sticky flags: a new error takes priority over a clear
  always_comb begin
    frame_err_d = bus.clr_err_i ? 1'b0 : frame_err_q;
    overrun_d   = bus.clr_err_i ? 1'b0 : overrun_q;
    if (frame_evt_c)   frame_err_d = 1'b1;
    if (overrun_evt_c) overrun_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
    parity_err_d = bus.clr_err_i ? 1'b0 : parity_err_q;
    if (par_evt_c) parity_err_d = 1'b1;
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      rx_prev_q   <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push_c),
    .data_i  (shift_q),
    .pop_i   (bus.rd_en_i),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.rd_data_o   = fifo_head;
  assign bus.rx_valid_o  = !fifo_empty;
  assign bus.irq_o       = !fifo_empty;
  assign bus.frame_err_o = frame_err_q;
  assign bus.overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err_o = parity_err_q;
`endif

endmodule
